// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into an APB SETUP/ACCESS transfer
// and reports completion, completer error or access-phase timeout on a response strobe.
module apb_requester #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it is never compared.
  localparam int unsigned      CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                selx_d, enable_d, write_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_d;

  assign cmd_ready = (state_q == ST_IDLE) && !P_rst;

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    addr_d        = P_addr;
    selx_d        = P_selx;
    enable_d      = P_enable;
    write_d       = P_write;
    wdata_d       = P_wdata;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = ST_SETUP;
          addr_d   = cmd_addr;
          write_d  = cmd_write;
          selx_d   = 1'b1;
          enable_d = 1'b0;
          if (cmd_write) begin
            wdata_d = cmd_wdata;
          end
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        enable_d   = 1'b1;
        wait_cnt_d = '0;
      end

      ST_ACCESS: begin
        if (P_ready) begin
          state_d       = ST_IDLE;
          selx_d        = 1'b0;
          enable_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = P_slverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = P_write ? '0 : P_rdata;
        end else if (TIMEOUT_EN && (wait_cnt_q == CNT_LIMIT)) begin
          state_d       = ST_IDLE;
          selx_d        = 1'b0;
          enable_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, wait counter and output registers; reset abandons any transfer silently.
  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      P_addr      <= '0;
      P_selx      <= 1'b0;
      P_enable    <= 1'b0;
      P_write     <= 1'b0;
      P_wdata     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      P_addr      <= addr_d;
      P_selx      <= selx_d;
      P_enable    <= enable_d;
      P_write     <= write_d;
      P_wdata     <= wdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small completer model (wait states,
// error injection, hang) and a 16-entry memory behind it.
module tb_apb_requester;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          P_clk = 1'b0;
  logic          P_rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] P_addr;
  logic          P_selx, P_enable, P_write;
  logic [DW-1:0] P_wdata;
  logic          P_ready, P_slverr;
  logic [DW-1:0] P_rdata;

  int errors = 0;
  int checks = 0;

  apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .P_clk       (P_clk),
    .P_rst       (P_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .P_addr      (P_addr),
    .P_selx      (P_selx),
    .P_enable    (P_enable),
    .P_write     (P_write),
    .P_wdata     (P_wdata),
    .P_ready     (P_ready),
    .P_slverr    (P_slverr),
    .P_rdata     (P_rdata)
  );

  initial forever #5 P_clk = ~P_clk;

  // Completer model: unwritten locations read back 0xA0 + address.
  int            wait_states;
  int            wcnt = 0;
  logic          hang, err_val;
  logic [15:0]   wr_mask;
  logic [DW-1:0] mem [16];

  assign P_ready  = P_selx && P_enable && !hang && (wcnt == wait_states);
  assign P_slverr = err_val;
  assign P_rdata  = wr_mask[P_addr[3:0]] ? mem[P_addr[3:0]] : (32'hA0 + 32'(P_addr[3:0]));

  always @(posedge P_clk) begin
    if (P_selx && P_enable && !P_ready) wcnt <= wcnt + 1;
    else                                wcnt <= 0;
    if (P_rst) begin
      wr_mask <= '0;
    end else if (P_selx && P_enable && P_ready && P_write) begin
      mem[P_addr[3:0]]     <= P_wdata;
      wr_mask[P_addr[3:0]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while idle; returns at the falling edge after the accept edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge P_clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    P_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    wait_states = 0; hang = 1'b0; err_val = 1'b0;
    @(negedge P_clk);
    @(negedge P_clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_selx",      64'(P_selx),    64'(0));
    chk("rst_enable",    64'(P_enable),  64'(0));
    chk("rst_addr",      64'(P_addr),    64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    P_rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    // Zero-wait write addr=1 data=7.
    issue(1'b1, 32'd1, 32'd7);
    chk("wr1_setup_selx",   64'(P_selx),    64'(1));
    chk("wr1_setup_enable", 64'(P_enable),  64'(0));
    chk("wr1_setup_addr",   64'(P_addr),    64'(1));
    chk("wr1_setup_wdata",  64'(P_wdata),   64'(7));
    chk("wr1_setup_write",  64'(P_write),   64'(1));
    chk("wr1_busy",         64'(cmd_ready), 64'(0));
    @(negedge P_clk);
    chk("wr1_access_enable", 64'(P_enable),  64'(1));
    chk("wr1_access_selx",   64'(P_selx),    64'(1));
    chk("wr1_no_rsp_yet",    64'(rsp_valid), 64'(0));
    @(negedge P_clk);
    chk("wr1_rsp_valid",  64'(rsp_valid),   64'(1));
    chk("wr1_rsp_slverr", 64'(rsp_slverr),  64'(0));
    chk("wr1_rsp_rdata",  64'(rsp_rdata),   64'(0));
    chk("wr1_rsp_to",     64'(rsp_timeout), 64'(0));
    chk("wr1_end_selx",   64'(P_selx),      64'(0));
    chk("wr1_end_enable", 64'(P_enable),    64'(0));
    chk("wr1_ready_back", 64'(cmd_ready),   64'(1));
    @(negedge P_clk);
    chk("wr1_rsp_pulse", 64'(rsp_valid), 64'(0));
    chk("wr1_addr_kept", 64'(P_addr),    64'(1));

    // Read addr=1 with two wait states.
    wait_states = 2;
    issue(1'b0, 32'd1, 32'd0);
    chk("rd1_setup_enable", 64'(P_enable), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge P_clk);
      chk("rd1_wait_enable", 64'(P_enable),  64'(1));
      chk("rd1_wait_addr",   64'(P_addr),    64'(1));
      chk("rd1_wait_norsp",  64'(rsp_valid), 64'(0));
    end
    @(negedge P_clk);
    chk("rd1_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rd1_rsp_rdata", 64'(rsp_rdata), 64'(7));
    chk("rd1_end_enable", 64'(P_enable), 64'(0));
    wait_states = 0;

    // Back-to-back with cmd_valid held: write addr=2 data=5, then read addr=2.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd2; cmd_wdata = 32'd5;
    @(negedge P_clk);
    cmd_write = 1'b0; cmd_wdata = 32'hDEAD_BEEF;
    chk("b2b_busy0", 64'(cmd_ready), 64'(0));
    @(negedge P_clk);
    chk("b2b_busy1", 64'(cmd_ready), 64'(0));
    @(negedge P_clk);
    chk("b2b_wr_rsp",    64'(rsp_valid), 64'(1));
    chk("b2b_ready_now", 64'(cmd_ready), 64'(1));
    @(negedge P_clk);
    cmd_valid = 1'b0;
    chk("b2b_accepted",  64'(cmd_ready), 64'(0));
    chk("b2b_rd_selx",   64'(P_selx),    64'(1));
    chk("b2b_rd_write",  64'(P_write),   64'(0));
    chk("b2b_rd_addr",   64'(P_addr),    64'(2));
    chk("b2b_wdata_hold",64'(P_wdata),   64'(5));
    @(negedge P_clk);
    chk("b2b_rd_enable", 64'(P_enable), 64'(1));
    chk("b2b_wdata_acc", 64'(P_wdata),  64'(5));
    @(negedge P_clk);
    chk("b2b_rd_rsp",   64'(rsp_valid), 64'(1));
    chk("b2b_rd_rdata", 64'(rsp_rdata), 64'(5));

    // Completer error on write addr=3, then a clean read.
    err_val = 1'b1;
    issue(1'b1, 32'd3, 32'd9);
    @(negedge P_clk);
    @(negedge P_clk);
    chk("err_rsp_valid",  64'(rsp_valid),   64'(1));
    chk("err_rsp_slverr", 64'(rsp_slverr),  64'(1));
    chk("err_rsp_to",     64'(rsp_timeout), 64'(0));
    err_val = 1'b0;
    issue(1'b0, 32'd3, 32'd0);
    @(negedge P_clk);
    @(negedge P_clk);
    chk("after_err_valid",  64'(rsp_valid),  64'(1));
    chk("after_err_slverr", 64'(rsp_slverr), 64'(0));
    chk("after_err_rdata",  64'(rsp_rdata),  64'(9));

    // Timeout: completer never ready, read addr=4 (memory would return 0xA4).
    hang = 1'b1;
    issue(1'b0, 32'd4, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge P_clk);
      chk("to_no_rsp", 64'(rsp_valid), 64'(0));
      chk("to_enable", 64'(P_enable),  64'(1));
    end
    @(negedge P_clk);
    chk("to_rsp_valid",  64'(rsp_valid),   64'(1));
    chk("to_rsp_slverr", 64'(rsp_slverr),  64'(1));
    chk("to_rsp_to",     64'(rsp_timeout), 64'(1));
    chk("to_rsp_rdata",  64'(rsp_rdata),   64'(0));
    chk("to_end_selx",   64'(P_selx),      64'(0));
    chk("to_cmd_ready",  64'(cmd_ready),   64'(1));
    hang = 1'b0;
    @(negedge P_clk);
    chk("to_pulse",   64'(rsp_valid),   64'(0));
    chk("to_to_hold", 64'(rsp_timeout), 64'(1));

    // Reset in the middle of ACCESS for read addr=5.
    wait_states = 3;
    issue(1'b0, 32'd5, 32'd0);
    @(negedge P_clk);
    chk("rst5_in_access", 64'(P_enable), 64'(1));
    P_rst = 1'b1;
    #1;
    chk("rst5_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge P_clk);
    P_rst = 1'b0;
    chk("rst5_selx",   64'(P_selx),      64'(0));
    chk("rst5_enable", 64'(P_enable),    64'(0));
    chk("rst5_addr",   64'(P_addr),      64'(0));
    chk("rst5_write",  64'(P_write),     64'(0));
    chk("rst5_wdata",  64'(P_wdata),     64'(0));
    chk("rst5_rsp_to", 64'(rsp_timeout), 64'(0));
    chk("rst5_rsp_sl", 64'(rsp_slverr),  64'(0));
    chk("rst5_rdata",  64'(rsp_rdata),   64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("rst5_no_rsp", 64'(rsp_valid), 64'(0));
      @(negedge P_clk);
    end
    wait_states = 0;
    issue(1'b0, 32'd6, 32'd0);
    @(negedge P_clk);
    @(negedge P_clk);
    chk("rd6_rsp_valid",  64'(rsp_valid),  64'(1));
    chk("rd6_rsp_rdata",  64'(rsp_rdata),  64'(32'hA6));
    chk("rd6_rsp_slverr", 64'(rsp_slverr), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
